fifo_wr_arb: RTL
================

// Module: fifo_wr_arb
// PURPOSE
//  Write-side controller for the async FIFO, in the wclk domain. Round-robin arbitrates
//  NREQ requesters onto the single FIFO write port and owns the write pointer (binary + gray).
//  Computes wfull from the synchronized gray read pointer wq2_rptr (output of sync_r2w).
//  Its wptr output feeds sync_w2r.
// PARAMETERS
//  DSIZE     8  data width per requester
//  ADDRSIZE  4  FIFO address width; depth = 2**ADDRSIZE; legal range >= 2
//  NREQ      4  number of requesters; legal range 2..16
//  AF_THRESH 2  almost-full margin in entries (ALMOST_FULL_EN only); legal range 1..2**ADDRSIZE-1
// PORTS
//  wclk      in   1                write clock
//  wrst_n    in   1                async active-low reset
//  req       in   NREQ             per-requester write request; held until granted
//  req_data  in   NREQ*DSIZE       packed data; slice i = [i*DSIZE +: DSIZE]
//  gnt       out  NREQ             one-hot grant; write of slice i occurs at this edge
//  wen       out  1                memory write enable (= |gnt)
//  waddr     out  ADDRSIZE         memory write address
//  wdata     out  DSIZE            memory write data (granted slice)
//  wptr      out  ADDRSIZE+1       registered gray write pointer -> sync_w2r
//  wq2_rptr  in   ADDRSIZE+1       gray read pointer, already synchronized to wclk
//  wfull     out  1                registered full flag
//  wafull    out  1                registered almost-full flag (0 when the feature is off)
// BEHAVIOUR
//  - Reset (async assert, sync release): wbin=0, wptr=0, wfull=0, wafull=0, rr_ptr=0.
//    gnt, wen and wdata are then 0 (combinational from state; no grant while in reset).
//  - Arbitration is combinational in the same cycle.
//    - If wfull=1: gnt=0.
//    - Else gnt = first asserted req scanning from index rr_ptr upward, modulo NREQ.
//  - On an edge with wen=1:
//    - wbin += 1, modulo 2**(ADDRSIZE+1).
//    - wptr <= bin2gray(wbin+1).
//    - rr_ptr <= (granted index + 1) mod NREQ.
//  - On an edge with no grant, rr_ptr holds.
//  - waddr = wbin[ADDRSIZE-1:0]; wdata = granted slice; wdata = 0 when there is no grant.
//  - Full: wfull <= (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}),
//    where wgraynext = bin2gray(wbin + wen).
//    - Asserts on the same edge as the write that fills the FIFO.
//    - Deasserts one wclk after wq2_rptr advances. This is pessimistic by design.
//  - Max throughput: one write per cycle. Requests are never dropped: an ungranted req waits.
//  - Starvation-free: a continuously asserted req is granted within NREQ grants.
//  - Pointer wrap: the MSB toggles every 2**ADDRSIZE writes; the gray code stays single-bit-change.
//  - Reset mid-operation: all state clears immediately; any in-flight write is not performed.
// CONFIGURATION
//  ALMOST_FULL_EN defined:
//   - level = (wbin + wen - gray2bin(wq2_rptr)) mod 2**(ADDRSIZE+1).
//   - wafull <= (level >= 2**ADDRSIZE - AF_THRESH).
//  ALMOST_FULL_EN undefined: wafull tied 0; no gray2bin logic.
// STRUCTURE
//  - Package fifo_pkg holds:
//    - function bin2gray(b): b ^ (b>>1).
//    - function gray2bin(g): xor-prefix scan.
//    - Shared by the read-side controller.
//  - Sub-module rr_arb #(N): req, rr_ptr in; one-hot gnt and encoded idx out; purely combinational.
//  - Pointer, flags and rr_ptr registers stay in fifo_wr_arb.
// TESTING (ADDRSIZE=2, NREQ=3, DSIZE=8)
//  1. Reset: assert wrst_n=0 mid-stream -> gnt, wen, wptr, wfull, waddr all 0 immediately.
//  2. Fill: req=3'b010 held, wq2_rptr=0.
//     -> 4 writes at waddr 0,1,2,3; wptr 001,011,010,110.
//     -> wfull=1 after the 4th edge; gnt=0 afterwards.
//  3. Fairness: req=3'b111 held, read side drains freely -> grant order 0,1,2,0,1,2.
//  4. Full release: while full, drive wq2_rptr=3'b001 -> wfull=0 next edge; next write goes to waddr 0.
//  5. Wrap: 12 writes, with reads keeping pace -> wptr cycles 000..100 and back to 000;
//     wfull never falsely asserts.
//  6. ALMOST_FULL_EN, AF_THRESH=1, wq2_rptr=0 -> wafull=1 after the 3rd write, wfull=0;
//     with the macro undefined, wafull stays 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Pointer-code helpers shared by the write- and read-side FIFO controllers.
// Functions work on a 32-bit container; callers cast the result down to their pointer width.
package fifo_pkg;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Requester, memory write port and pointer-exchange bundle of the FIFO write side.
// Combinational grant/write signals; registered wptr/wfull/wafull.
interface fifo_wr_arb_if #(
    parameter int DSIZE    = 8,
    parameter int ADDRSIZE = 4,
    parameter int NREQ     = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  wen;
    logic [ADDRSIZE-1:0]   waddr;
    logic [DSIZE-1:0]      wdata;
    logic [ADDRSIZE:0]     wptr;
    logic [ADDRSIZE:0]     wq2_rptr;
    logic                  wfull;
    logic                  wafull;

    modport master (
        output req, req_data, wq2_rptr,
        input  gnt, wen, waddr, wdata, wptr, wfull, wafull
    );

    modport slave (
        input  req, req_data, wq2_rptr,
        output gnt, wen, waddr, wdata, wptr, wfull, wafull
    );
endinterface

// File: rtl/fifo_wr_arb_rr_arb.sv
// Round-robin picker: first asserted req scanning upward from rr_ptr, modulo N.
// Zero latency (purely combinational); no backpressure of its own.
module rr_arb #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    logic found;
    int   pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < N; i++) begin
            pos = (int'(rr_ptr) + i) % N;
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IW'(pos);
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arb.sv
// FIFO write-side controller: round-robin grant onto the write port, gray wptr, wfull (+ wafull with ALMOST_FULL_EN).
// Grant/write same cycle, flags/pointer registered; ungranted requests wait, nothing granted while full or in reset.
module fifo_wr_arb
    import fifo_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int ADDRSIZE  = 4,
    parameter int NREQ      = 4,
    parameter int AF_THRESH = 2
) (
    input  logic          wclk,
    input  logic          wrst_n,
    fifo_wr_arb_if.slave  bus
);
    localparam int AW = ADDRSIZE;
    localparam int PW = ADDRSIZE + 1;
    localparam int IW = $clog2(NREQ);

    if (ADDRSIZE < 2 || NREQ < 2 || NREQ > 16 ||
        AF_THRESH < 1 || AF_THRESH > (2**ADDRSIZE) - 1) begin : g_param_err
        $error("fifo_wr_arb: parameter out of legal range");
    end

    logic [PW-1:0]   wbin_q, wbin_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   wgray_next;
    logic            wfull_q, wfull_d;
    logic            wafull_q, wafull_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   gnt_idx;
    logic [NREQ-1:0] req_elig;
    logic [NREQ-1:0] gnt;
    logic            wen;

    // Reset is folded in so no grant can leak out while the pointer state is being cleared.
    assign req_elig = bus.req & {NREQ{wrst_n & ~wfull_q}};

    rr_arb #(.N(NREQ), .IW(IW)) u_rr_arb (
        .req    (req_elig),
        .rr_ptr (rr_ptr_q),
        .gnt    (gnt),
        .idx    (gnt_idx)
    );

    assign wen = |gnt;

`ifdef ALMOST_FULL_EN
    logic [PW-1:0] rbin;
    logic [PW-1:0] level;
`endif

    always_comb begin
        wbin_d     = wbin_q + PW'(wen);
        wgray_next = PW'(bin2gray(32'(wbin_d)));
        wptr_d     = wgray_next;
        // Full when the next write pointer equals the read pointer with its two top gray bits flipped.
        wfull_d    = (wgray_next == {~bus.wq2_rptr[AW:AW-1], bus.wq2_rptr[AW-2:0]});
        rr_ptr_d   = rr_ptr_q;
        if (wen) begin
            rr_ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
        end
`ifdef ALMOST_FULL_EN
        rbin     = PW'(gray2bin(32'(bus.wq2_rptr)));
        level    = wbin_d - rbin;
        wafull_d = (level >= PW'((2**AW) - AF_THRESH));
`else
        wafull_d = 1'b0;
`endif
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.gnt    = gnt;
    assign bus.wen    = wen;
    assign bus.waddr  = wbin_q[AW-1:0];
    assign bus.wdata  = wen ? bus.req_data[gnt_idx*DSIZE +: DSIZE] : '0;
    assign bus.wptr   = wptr_q;
    assign bus.wfull  = wfull_q;
    assign bus.wafull = wafull_q;
endmodule
